key_insert: RTL and testbench

KEY_INSERT -- requirements
Module: key_insert

---
 rtl/key_insert_pkg.sv | 30 +++
 rtl/key_insert_merge.sv | 82 ++++++++
 rtl/key_insert.sv | 149 ++++++++++++++
 tb/tb_key_insert.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_insert_pkg.sv
// Shared constants for the key extract/insert pair: container widths, field
// order inside the key, offset-word slot layout and the insert FSM encoding.
package key_insert_pkg;

  localparam int WIDTH_2B   = 16;
  localparam int WIDTH_4B   = 32;
  localparam int WIDTH_6B   = 48;
  localparam int META_W     = 256;
  localparam int IDX_W      = 3;
  localparam int NUM_FIELDS = 6;
  // Only the top NUM_FIELDS*IDX_W bits of the offset word carry indices.
  localparam int OFF_USED   = NUM_FIELDS * IDX_W;

  // Field / offset-slot order, MSB first.
  localparam int SLOT_6B_A = 0;
  localparam int SLOT_6B_B = 1;
  localparam int SLOT_4B_A = 2;
  localparam int SLOT_4B_B = 3;
  localparam int SLOT_2B_A = 4;
  localparam int SLOT_2B_B = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KEY,
    WAIT_PHV,
    WRITE,
    OUT
  } state_t;

endpackage

// File: rtl/key_insert_merge.sv
// Combinational masked scatter of the six key fields into the PHV containers.
// Key here excludes the compare bit: fields run 6B_a..2B_b from the MSB down.
// Optional: KEY_INSERT_CONFLICT_CHK_EN adds the same-index collision flag.
module key_insert_merge
  import key_insert_pkg::*;
#(
  parameter int NUM_PER_TYPE = 8,
  parameter int PHV_LEN      = 1024,
  parameter int KW           = 192
) (
  input  logic [PHV_LEN-1:0]                 phv,
  input  logic [KW-1:0]                      key,
  input  logic [KW-1:0]                      mask,
  input  logic [NUM_FIELDS-1:0][IDX_W-1:0]   idx,
  output logic [PHV_LEN-1:0]                 merged
`ifdef KEY_INSERT_CONFLICT_CHK_EN
  ,
  output logic                               conflict
`endif
);

  localparam int B6  = PHV_LEN - WIDTH_6B * NUM_PER_TYPE;
  localparam int B4  = META_W + WIDTH_2B * NUM_PER_TYPE;
  localparam int B2  = META_W;
  localparam int F6A = KW - WIDTH_6B;
  localparam int F6B = F6A - WIDTH_6B;
  localparam int F4A = F6B - WIDTH_4B;
  localparam int F4B = F4A - WIDTH_4B;
  localparam int F2A = F4B - WIDTH_2B;
  localparam int F2B = F2A - WIDTH_2B;

  assign merged[META_W-1:0] = phv[META_W-1:0];

  for (genvar i = 0; i < NUM_PER_TYPE; i++) begin : g_6b
    logic [WIDTH_6B-1:0] orig, res;
    assign orig = phv[B6 + i*WIDTH_6B +: WIDTH_6B];
    // _b is tested first so it owns a shared index outright
    always_comb begin
      res = orig;
      if (idx[SLOT_6B_B] == IDX_W'(i))
        res = (orig & mask[F6B +: WIDTH_6B]) | (key[F6B +: WIDTH_6B] & ~mask[F6B +: WIDTH_6B]);
      else if (idx[SLOT_6B_A] == IDX_W'(i))
        res = (orig & mask[F6A +: WIDTH_6B]) | (key[F6A +: WIDTH_6B] & ~mask[F6A +: WIDTH_6B]);
    end
    assign merged[B6 + i*WIDTH_6B +: WIDTH_6B] = res;
  end

  for (genvar i = 0; i < NUM_PER_TYPE; i++) begin : g_4b
    logic [WIDTH_4B-1:0] orig, res;
    assign orig = phv[B4 + i*WIDTH_4B +: WIDTH_4B];
    // _b is tested first so it owns a shared index outright
    always_comb begin
      res = orig;
      if (idx[SLOT_4B_B] == IDX_W'(i))
        res = (orig & mask[F4B +: WIDTH_4B]) | (key[F4B +: WIDTH_4B] & ~mask[F4B +: WIDTH_4B]);
      else if (idx[SLOT_4B_A] == IDX_W'(i))
        res = (orig & mask[F4A +: WIDTH_4B]) | (key[F4A +: WIDTH_4B] & ~mask[F4A +: WIDTH_4B]);
    end
    assign merged[B4 + i*WIDTH_4B +: WIDTH_4B] = res;
  end

  for (genvar i = 0; i < NUM_PER_TYPE; i++) begin : g_2b
    logic [WIDTH_2B-1:0] orig, res;
    assign orig = phv[B2 + i*WIDTH_2B +: WIDTH_2B];
    // _b is tested first so it owns a shared index outright
    always_comb begin
      res = orig;
      if (idx[SLOT_2B_B] == IDX_W'(i))
        res = (orig & mask[F2B +: WIDTH_2B]) | (key[F2B +: WIDTH_2B] & ~mask[F2B +: WIDTH_2B]);
      else if (idx[SLOT_2B_A] == IDX_W'(i))
        res = (orig & mask[F2A +: WIDTH_2B]) | (key[F2A +: WIDTH_2B] & ~mask[F2A +: WIDTH_2B]);
    end
    assign merged[B2 + i*WIDTH_2B +: WIDTH_2B] = res;
  end

`ifdef KEY_INSERT_CONFLICT_CHK_EN
  assign conflict = (idx[SLOT_6B_A] == idx[SLOT_6B_B]) |
                    (idx[SLOT_4B_A] == idx[SLOT_4B_B]) |
                    (idx[SLOT_2B_A] == idx[SLOT_2B_B]);
`endif

endmodule

// File: rtl/key_insert.sv
// Key insert: joins a PHV and a result key, scatters the key fields back into
// the PHV containers and presents the merged PHV with a valid/ready handshake.
// Optional: KEY_INSERT_CONFLICT_CHK_EN adds the conflict_err output.
module key_insert
  import key_insert_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 512,
  parameter int NUM_PER_TYPE        = 8,
  parameter int PHV_LEN             = 48*NUM_PER_TYPE + 32*NUM_PER_TYPE + 16*NUM_PER_TYPE + 256,
  parameter int KEY_LEN             = 48*2 + 32*2 + 16*2 + 1,
  parameter int KEY_OFF             = (3+3)*3 + 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_valid_in,
  output logic               phv_ready_out,
  input  logic [KEY_LEN-1:0] key_in,
  input  logic [KEY_OFF-1:0] key_offset_in,
  input  logic [KEY_LEN-1:0] key_mask_in,
  input  logic               key_valid_in,
  output logic               key_ready_out,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_valid_out,
  input  logic               ready_in
`ifdef KEY_INSERT_CONFLICT_CHK_EN
  ,
  output logic               conflict_err
`endif
);

  localparam int KW = KEY_LEN - 1;

  state_t                           state, state_n;
  logic [PHV_LEN-1:0]               phv_q, merged, merged_q;
  logic [KW-1:0]                    key_q, mask_q;
  logic [OFF_USED-1:0]              off_q;
  logic [NUM_FIELDS-1:0][IDX_W-1:0] idx;
  logic [1:0]                       vld_pipe;
  logic                             cap_phv, cap_key, go_write;

  // Compare bit, unused offset bits and the AXIS width never reach the datapath.
  logic unused_bits;
  assign unused_bits = ^{key_in[0], key_mask_in[0], key_offset_in[KEY_OFF-OFF_USED-1:0]} ^
                       (C_S_AXIS_DATA_WIDTH > 0);

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_idx
    assign idx[k] = off_q[OFF_USED-1-k*IDX_W -: IDX_W];
  end

`ifdef KEY_INSERT_CONFLICT_CHK_EN
  logic conflict, conf_q;
`endif

  key_insert_merge #(
    .NUM_PER_TYPE (NUM_PER_TYPE),
    .PHV_LEN      (PHV_LEN),
    .KW           (KW)
  ) u_merge (
    .phv      (phv_q),
    .key      (key_q),
    .mask     (mask_q),
    .idx      (idx),
    .merged   (merged)
`ifdef KEY_INSERT_CONFLICT_CHK_EN
    ,
    .conflict (conflict)
`endif
  );

  assign cap_phv  = phv_valid_in & phv_ready_out;
  assign cap_key  = key_valid_in & key_ready_out;
  assign go_write = (state_n == WRITE) && (state != WRITE);

  // Next state and readies; readies are held low while reset is applied.
  always_comb begin
    state_n       = state;
    phv_ready_out = 1'b0;
    key_ready_out = 1'b0;
    case (state)
      IDLE: begin
        phv_ready_out = rst_n;
        key_ready_out = rst_n;
        if (phv_valid_in && key_valid_in) state_n = WRITE;
        else if (phv_valid_in)            state_n = WAIT_KEY;
        else if (key_valid_in)            state_n = WAIT_PHV;
      end
      WAIT_KEY: begin
        key_ready_out = rst_n;
        if (key_valid_in) state_n = WRITE;
      end
      WAIT_PHV: begin
        phv_ready_out = rst_n;
        if (phv_valid_in) state_n = WRITE;
      end
      WRITE:   if (vld_pipe[1]) state_n = OUT;
      OUT:     if (ready_in)    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Capture, two-stage merge pipeline (scatter result, then output register) and output hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      phv_q         <= '0;
      key_q         <= '0;
      mask_q        <= '0;
      off_q         <= '0;
      merged_q      <= '0;
      vld_pipe      <= '0;
      phv_out       <= '0;
      phv_valid_out <= 1'b0;
`ifdef KEY_INSERT_CONFLICT_CHK_EN
      conf_q        <= 1'b0;
      conflict_err  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      vld_pipe <= {vld_pipe[0], go_write};
      if (cap_phv) phv_q <= phv_in;
      if (cap_key) begin
        key_q  <= key_in[KEY_LEN-1:1];
        mask_q <= key_mask_in[KEY_LEN-1:1];
        off_q  <= key_offset_in[KEY_OFF-1 -: OFF_USED];
      end
      if (vld_pipe[0]) begin
        merged_q <= merged;
`ifdef KEY_INSERT_CONFLICT_CHK_EN
        conf_q   <= conflict;
`endif
      end
      if (vld_pipe[1]) begin
        phv_out       <= merged_q;
        phv_valid_out <= 1'b1;
`ifdef KEY_INSERT_CONFLICT_CHK_EN
        conflict_err  <= conf_q;
`endif
      end
      if (state == OUT && ready_in) begin
        phv_valid_out <= 1'b0;
`ifdef KEY_INSERT_CONFLICT_CHK_EN
        conflict_err  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_key_insert.sv
// Scoreboard bench for key_insert: stimulus pushes expected PHVs, a negedge
// monitor pops and compares on each output handshake.
module tb_key_insert;

  localparam int N  = 8;
  localparam int PL = 1024;
  localparam int KL = 193;
  localparam int KO = 38;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PL-1:0] phv_in = '0;
  logic          phv_valid_in = 1'b0;
  logic          phv_ready_out;
  logic [KL-1:0] key_in = '0;
  logic [KO-1:0] key_offset_in = '0;
  logic [KL-1:0] key_mask_in = '0;
  logic          key_valid_in = 1'b0;
  logic          key_ready_out;
  logic [PL-1:0] phv_out;
  logic          phv_valid_out;
  logic          ready_in = 1'b1;
`ifdef KEY_INSERT_CONFLICT_CHK_EN
  logic          conflict_err;
`endif

  always #5 clk = ~clk;

  key_insert dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .phv_in        (phv_in),
    .phv_valid_in  (phv_valid_in),
    .phv_ready_out (phv_ready_out),
    .key_in        (key_in),
    .key_offset_in (key_offset_in),
    .key_mask_in   (key_mask_in),
    .key_valid_in  (key_valid_in),
    .key_ready_out (key_ready_out),
    .phv_out       (phv_out),
    .phv_valid_out (phv_valid_out),
    .ready_in      (ready_in)
`ifdef KEY_INSERT_CONFLICT_CHK_EN
    ,
    .conflict_err  (conflict_err)
`endif
  );

  typedef struct {
    logic [PL-1:0] phv;
    logic          conf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   popped = 0;

  task automatic chk(input string name, input logic [PL-1:0] act, input logic [PL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Container placement straight from the MSB-first layout.
  function automatic logic [PL-1:0] put6(input logic [PL-1:0] p, input int i, input logic [47:0] v);
    p[PL-1-(N-1-i)*48 -: 48] = v;
    return p;
  endfunction
  function automatic logic [PL-1:0] put4(input logic [PL-1:0] p, input int i, input logic [31:0] v);
    p[PL-1-N*48-(N-1-i)*32 -: 32] = v;
    return p;
  endfunction
  function automatic logic [PL-1:0] put2(input logic [PL-1:0] p, input int i, input logic [15:0] v);
    p[PL-1-N*48-N*32-(N-1-i)*16 -: 16] = v;
    return p;
  endfunction
  function automatic logic [KL-1:0] mk_key(input logic [47:0] a6, input logic [47:0] b6,
                                           input logic [31:0] a4, input logic [31:0] b4,
                                           input logic [15:0] a2, input logic [15:0] b2,
                                           input logic c);
    return {a6, b6, a4, b4, a2, b2, c};
  endfunction
  function automatic logic [KO-1:0] mk_off(input logic [2:0] s0, input logic [2:0] s1,
                                           input logic [2:0] s2, input logic [2:0] s3,
                                           input logic [2:0] s4, input logic [2:0] s5);
    return {s0, s1, s2, s3, s4, s5, 20'h5A5A5};
  endfunction
  function automatic logic [PL-1:0] base(input logic [7:0] seed);
    logic [PL-1:0] p;
    for (int j = 0; j < PL/32; j++) p[j*32 +: 32] = {seed, 8'(j), ~seed, 8'(j*3)};
    return p;
  endfunction

  // Full-key vector: every field written, mask all zero.
  logic [KL-1:0] key_a, mask_z, key_c, mask_c;
  logic [KO-1:0] off_std;
  function automatic logic [PL-1:0] exp_full(input logic [PL-1:0] p);
    p = put6(p, 3, 48'h112233445566);
    p = put6(p, 5, 48'hA1A2A3A4A5A6);
    p = put4(p, 1, 32'h01020304);
    p = put4(p, 2, 32'h0A0B0C0D);
    p = put2(p, 6, 16'h1111);
    p = put2(p, 7, 16'h2222);
    return p;
  endfunction

  task automatic push(input logic [PL-1:0] p, input logic c);
    exp_t e;
    e.phv  = p;
    e.conf = c;
    sb.push_back(e);
  endtask

  task automatic drive_both(input logic [PL-1:0] p, input logic [KL-1:0] k,
                            input logic [KO-1:0] o, input logic [KL-1:0] m);
    bit ok = 0;
    phv_in = p; key_in = k; key_offset_in = o; key_mask_in = m;
    phv_valid_in = 1'b1; key_valid_in = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = phv_ready_out && key_ready_out;
      @(posedge clk); #1;
    end
    phv_valid_in = 1'b0; key_valid_in = 1'b0;
    chk("handshake_both", ok, 1'b1);
  endtask

  task automatic drive_phv(input logic [PL-1:0] p);
    bit ok = 0;
    phv_in = p; phv_valid_in = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = phv_ready_out;
      @(posedge clk); #1;
    end
    phv_valid_in = 1'b0;
    chk("handshake_phv", ok, 1'b1);
  endtask

  task automatic drive_key(input logic [KL-1:0] k, input logic [KO-1:0] o, input logic [KL-1:0] m);
    bit ok = 0;
    key_in = k; key_offset_in = o; key_mask_in = m; key_valid_in = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = key_ready_out;
      @(posedge clk); #1;
    end
    key_valid_in = 1'b0;
    chk("handshake_key", ok, 1'b1);
  endtask

  // Called just after the capturing edge; counts edges until valid rises.
  task automatic check_latency(input string name);
    int edges = 0;
    while (!phv_valid_out && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk(name, edges, 2);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (phv_valid_out && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", phv_valid_out, 1'b0);
  endtask

  // Monitor: one comparison per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && phv_valid_out && ready_in) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h expected none", phv_out);
        end else begin
          e = sb.pop_front();
          chk("phv_out", phv_out, e.phv);
`ifdef KEY_INSERT_CONFLICT_CHK_EN
          chk("conflict_err", conflict_err, e.conf);
`endif
          popped++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [PL-1:0] p;
    key_a   = mk_key(48'h112233445566, 48'hA1A2A3A4A5A6, 32'h01020304, 32'h0A0B0C0D,
                     16'h1111, 16'h2222, 1'b1);
    mask_z  = '0;
    off_std = mk_off(3'd3, 3'd5, 3'd1, 3'd2, 3'd6, 3'd7);
    key_c   = mk_key(48'h0, 48'h0, 32'hDEADBEEF, 32'h0, 16'h0, 16'h0, 1'b0);
    mask_c  = mk_key('1, '1, 32'hFFFF0000, '1, '1, '1, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_phv_out", phv_out, '0);
    chk("rst_valid", phv_valid_out, 1'b0);
    chk("rst_readies", {phv_ready_out, key_ready_out}, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_readies", {phv_ready_out, key_ready_out}, 2'b11);
    @(posedge clk); #1;

    // Both valid in one cycle, full key, mask zero
    p = base(8'h11);
    push(exp_full(p), 1'b0);
    drive_both(p, key_a, off_std, mask_z);
    @(negedge clk);
    chk("write_readies", {phv_ready_out, key_ready_out}, 2'b00);
    check_latency("latency_both");
    wait_drain();

    // PHV first, key three cycles later
    p = base(8'h22);
    push(exp_full(p), 1'b0);
    drive_phv(p);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_key_readies", {phv_ready_out, key_ready_out}, 2'b01);
      @(posedge clk); #1;
    end
    drive_key(key_a, off_std, mask_z);
    check_latency("latency_key_last");
    @(negedge clk);
    chk("out_phv_ready", phv_ready_out, 1'b0);
    wait_drain();

    // Partial mask on 4B_a
    p = put4(base(8'h33), 1, 32'h12345678);
    push(put4(p, 1, 32'h1234BEEF), 1'b0);
    drive_both(p, key_c, off_std, mask_c);
    check_latency("latency_mask");
    wait_drain();

    // 2B_a and 2B_b on the same index: _b wins
    p = base(8'h44);
    push(put2(p, 6, 16'h5555), 1'b1);
    drive_both(p, mk_key(48'h0, 48'h0, 32'h0, 32'h0, 16'hAAAA, 16'h5555, 1'b0),
               mk_off(3'd3, 3'd5, 3'd1, 3'd2, 3'd6, 3'd6),
               mk_key('1, '1, '1, '1, 16'h0, 16'h0, 1'b0));
    check_latency("latency_conflict");
    wait_drain();

    // Back-pressure: output held five cycles
    ready_in = 1'b0;
    p = base(8'h55);
    push(exp_full(p), 1'b0);
    drive_both(p, key_a, off_std, mask_z);
    check_latency("latency_stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_phv_out", phv_out, exp_full(p));
      chk("stall_valid_readies", {phv_valid_out, phv_ready_out, key_ready_out}, 3'b100);
      @(posedge clk); #1;
    end
    ready_in = 1'b1;
    wait_drain();

    // Reset while holding output
    ready_in = 1'b0;
    drive_both(base(8'h99), key_a, off_std, mask_z);
    check_latency("latency_pre_reset");
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", phv_valid_out, 1'b0);
    chk("rst_out_phv", phv_out, '0);
    @(negedge clk);
    chk("rst_out_readies", {phv_ready_out, key_ready_out}, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {phv_ready_out, key_ready_out}, 2'b11);
    @(posedge clk); #1;

    // Reset in WAIT_KEY drops the captured PHV
    drive_phv(base(8'h66));
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_idle", {phv_ready_out, key_ready_out}, 2'b11);
    @(posedge clk); #1;
    drive_key(key_c, off_std, mask_c);
    @(negedge clk);
    chk("wait_phv_readies", {phv_ready_out, key_ready_out}, 2'b10);
    @(posedge clk); #1;
    p = put4(base(8'h77), 1, 32'h12345678);
    push(put4(p, 1, 32'h1234BEEF), 1'b0);
    drive_phv(p);
    check_latency("latency_phv_last");
    wait_drain();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("outputs_seen", popped, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
